dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipeline's MEM stage: it receives one load or store request at a time over a valid/ready handshake. It waits a parameterised access latency, then performs the word access on an internal byte-writable array. It returns read data or a store acknowledgement over a second valid/ready handshake, so MEM can be modelled against a realistic multi-cycle data cache.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10, gives the array depth in 32-bit words (2^DEPTH_LOG2).
- `LATENCY`, default 2, is the number of cycles from request accept to response valid. The legal range is 1..15.

Ports:
- `clk`, in, 1 bit: the only clock. All logic is on the rising edge.
- `rst`, in, 1 bit: synchronous, active-high reset.
- `req_valid`, in, 1 bit: a request is present.
- `req_ready`, out, 1 bit: the block can accept a request.
- `req_addr`, in, 32 bits: byte address.
- `req_wen`, in, 1 bit: 1 means store, 0 means load.
- `req_wdata`, in, 32 bits: store data.
- `req_be`, in, 4 bits: store byte enables. Bit i enables byte i (bits [8i+7:8i]).
- `rsp_valid`, out, 1 bit: a response is present.
- `rsp_ready`, in, 1 bit: the consumer accepts the response.
- `rsp_rdata`, out, 32 bits: load data. It is 0 for stores and for errors.
- `rsp_err`, out, 1 bit: the request was misaligned or out of range.

## Operation
- The block keeps a single outstanding request. The FSM has three states: IDLE, WAIT and RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid & req_ready`, capture addr, wen, wdata and be, load the counter with LATENCY-1, and go to WAIT.
- WAIT:
  - `req_ready` = 0. The counter decrements each cycle.
  - On the edge where the counter is 0, perform the access and go to RESP.
- Access rules:
  - Error if `addr[1:0]` ≠ 0 or `addr[31:DEPTH_LOG2+2]` ≠ 0. On error: no array write, `rsp_rdata` = 0, `rsp_err` = 1.
  - Load: `rsp_rdata` = the full word at `addr[DEPTH_LOG2+1:2]`. `req_be` is ignored.
  - Store: write only the enabled bytes. Other bytes are unchanged. `be` = 0 is a legal no-op store with `rsp_err` = 0 and `rsp_rdata` = 0.
- RESP:
  - `rsp_valid` = 1. `rsp_rdata` and `rsp_err` are held stable until `rsp_valid & rsp_ready`, then the FSM goes to IDLE.
  - `req_valid` asserted during WAIT or RESP is not accepted (`req_ready` = 0). The requester must hold it.
- Array contents are not cleared by `rst`. They are undefined until written.

## Timing
- Reset values, while `rst` = 1 and on the edge it is sampled:
  - state = IDLE; `req_ready` = 0, since it is gated by `!rst`.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
  - The counter is 0.
  - `req_ready` is 1 in the first cycle after `rst` deasserts.
- Latency: a request handshake on edge E0 makes `rsp_valid` high from edge E0+LATENCY.
- Throughput: with `rsp_ready` tied high, the response handshakes on E0+LATENCY+1. The next request can handshake on E0+LATENCY+2, so the minimum period is LATENCY+2 cycles.
- Store visibility: a store performed at edge E0+LATENCY is visible to any load that performs its access later.
- Reset mid-operation: `rst` in WAIT or RESP aborts the request. Response registers clear and nothing is returned.
  - A store is not written if `rst` is sampled on or before its access edge.
  - If the access edge and the reset edge coincide, reset wins and no write occurs.
- Simultaneous events: `req_valid` rising in the same cycle as a RESP handshake is not accepted until the next cycle.

## Structure
- Shared package `dmem_pkg` holds:
  - the state enum (IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2);
  - the word and address width constants (32);
  - the byte-enable width (4).
- Sub-module `dmem_array` is a single-port synchronous RAM with a 4-bit byte write enable and registered read, sized 2^DEPTH_LOG2 × 32 bits.
- `dmem_responder` contains the FSM, the latency counter, the request capture registers, error detection and the response registers.

## Test plan
- Reset then idle: hold `rst` for 3 cycles → `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `req_ready` = 0 during reset and 1 on the first cycle after.
- Store then load, LATENCY = 2:
  - Store 0xDEADBEEF to 0x10 with be = 4'hF → the response arrives 2 cycles after accept with err = 0 and rdata = 0.
  - Load 0x10 → rdata = 0xDEADBEEF.
- Byte enables: after the above, store 0x11223344 to 0x10 with be = 4'b0101, then load 0x10 → rdata = 0xDE22BE44.
- Errors: load 0x12 → err = 1, rdata = 0. Store to 0x0000_1000 with DEPTH_LOG2 = 10 → err = 1, and a following load of 0x0 is unchanged.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles in RESP → `rsp_valid` and `rsp_rdata` stay stable, `req_ready` = 0, and the second pending request is accepted only after the response handshake.
- Reset mid-WAIT: store 0xCAFEF00D to 0x20, then assert `rst` one cycle after accept → no response. A subsequent load of 0x20 returns the previously written value.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory responder:
//                FSM state encoding, word/address widths, byte-enable width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   // Word and address widths of the MEM-stage data port
   localparam int c_word_w = 32;
   localparam int c_addr_w = 32;

   // One enable bit per byte lane of a word
   localparam int c_be_w   = 4;

   // Latency counter width, wide enough for LATENCY-1 up to 14
   localparam int c_cnt_w  = 4;

   // Responder FSM: one outstanding request at a time
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Single-port synchronous RAM, 2^DEPTH_LOG2 x 32 bits, with
//                per-byte write enables and a registered read port. The read
//                register holds its value until the next read access.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [c_be_w-1:0]     be,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [c_word_w-1:0]   wdata,
   output logic [c_word_w-1:0]   rdata
);

   localparam int c_depth = 2 ** DEPTH_LOG2;

   logic [c_word_w-1:0] r_mem [c_depth];
   logic [c_word_w-1:0] r_rdata;

   // Byte-lane writes: only lanes with their enable set are updated
   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int b = 0; b < c_be_w; b++) begin
            if (be[b]) begin
               r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   // Registered read; the output holds between read accesses
   always_ff @(posedge clk) begin
      if (en && !we) begin
         r_rdata <= r_mem[addr];
      end
   end

   assign rdata = r_rdata;

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : MEM-stage data-memory responder. Accepts one load/store
//                request over valid/ready, waits LATENCY cycles, performs the
//                word access on an internal byte-writable array and returns
//                read data or a store acknowledgement over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [c_addr_w-1:0] req_addr,
   input  logic                req_wen,
   input  logic [c_word_w-1:0] req_wdata,
   input  logic [c_be_w-1:0]   req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [c_word_w-1:0] rsp_rdata,
   output logic                rsp_err
);

   // Counter reload value: the access happens on the edge where it reads 0
   localparam logic [c_cnt_w-1:0] c_lat_m1 = c_cnt_w'(LATENCY - 1);

   dmem_state_t         r_state;
   dmem_state_t         w_state_nxt;
   logic [c_cnt_w-1:0]  r_count;
   logic [c_cnt_w-1:0]  w_count_nxt;

   // Captured request
   logic [c_addr_w-1:0] r_addr;
   logic                r_wen;
   logic [c_word_w-1:0] r_wdata;
   logic [c_be_w-1:0]   r_be;

   // Response state; r_rsp_load selects the RAM read register onto rsp_rdata
   logic                r_rsp_err;
   logic                r_rsp_load;

   logic                w_accept;
   logic                w_access;
   logic                w_err;
   logic                w_ram_en;
   logic                w_rsp_fire;
   logic [c_word_w-1:0] w_ram_rdata;

   // Misaligned, or beyond the top of the array
   assign w_err = (r_addr[1:0] != 2'b00) ||
                  ((r_addr >> (DEPTH_LOG2 + 2)) != '0);

   assign w_accept   = req_valid && req_ready;
   assign w_access   = (r_state == WAIT) && (r_count == '0);
   assign w_rsp_fire = rsp_valid && rsp_ready;

   // A reset sampled on the access edge suppresses the access entirely
   assign w_ram_en   = w_access && !w_err && !rst;

   // State and latency-counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   // Next-state, counter and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = !rst;
            if (req_valid && !rst) begin
               w_state_nxt = WAIT;
               w_count_nxt = c_lat_m1;
            end
         end
         WAIT: begin
            if (r_count == '0) begin
               w_state_nxt = RESP;
            end else begin
               w_count_nxt = r_count - 1'b1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
         end
      endcase
   end

   // Request capture on the accept handshake
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr  <= req_addr;
         r_wen   <= req_wen;
         r_wdata <= req_wdata;
         r_be    <= req_be;
      end
   end

   // Response flags: set at the access edge, held through RESP, cleared on
   // the response handshake so stale data never leaks into IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_err  <= 1'b0;
         r_rsp_load <= 1'b0;
      end else if (w_access) begin
         r_rsp_err  <= w_err;
         r_rsp_load <= !r_wen && !w_err;
      end else if (w_rsp_fire) begin
         r_rsp_err  <= 1'b0;
         r_rsp_load <= 1'b0;
      end
   end

   // The RAM read register doubles as the response data register
   dmem_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk   (clk),
      .en    (w_ram_en),
      .we    (r_wen),
      .be    (r_be),
      .addr  (r_addr[DEPTH_LOG2+1:2]),
      .wdata (r_wdata),
      .rdata (w_ram_rdata)
   );

   assign rsp_rdata = r_rsp_load ? w_ram_rdata : '0;
   assign rsp_err   = r_rsp_err;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder: directed scenarios
//                followed by randomized requests against a byte-level
//                reference memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

   localparam int L  = 2;
   localparam int DL = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_wen;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks   = 0;
   int failures = 0;

   // Reference memory: word contents plus a per-byte "has been written" mask
   logic [31:0] m_word  [int];
   logic [3:0]  m_known [int];

   always #5 clk = ~clk;

   dmem_responder #(
      .DEPTH_LOG2 (DL),
      .LATENCY    (L)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wen   (req_wen),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic m_is_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || (a >= (32'd4 << DL));
   endfunction

   // Apply a completed store to the model
   task automatic m_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      int idx = int'(a >> 2);
      if (!m_word.exists(idx)) begin
         m_word[idx]  = 32'h0;
         m_known[idx] = 4'h0;
      end
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            m_word[idx][8*i +: 8] = d[8*i +: 8];
            m_known[idx][i]       = 1'b1;
         end
      end
   endtask

   // Drive one request until handshake; returns 0 if never accepted
   task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] be, output bit ok);
      int n = 0;
      req_valid = 1'b1;
      req_addr  = a;
      req_wen   = w;
      req_wdata = d;
      req_be    = be;
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 32'(req_ready), 32'd1);
      ok = req_ready;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Full transaction with bp cycles of response backpressure
   task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] be, input int bp, output logic [31:0] got);
      bit          ok;
      int          n;
      int          idx = int'(a >> 2);
      logic        e   = m_is_err(a);
      logic [31:0] held;
      got = 32'hx;
      @(negedge clk);
      rsp_ready = (bp == 0);
      issue(a, w, d, be, ok);
      if (!ok) return;
      n = 1;
      while (!rsp_valid && n < L + 20) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n - 1), 32'(L));
      if (!rsp_valid) return;
      got = rsp_rdata;
      chk("rsp_err", 32'(rsp_err), 32'(e));
      if (w || e) begin
         chk("rsp_rdata_zero", rsp_rdata, 32'h0);
      end else if (m_known.exists(idx) && m_known[idx] == 4'hF) begin
         chk("load_data", rsp_rdata, m_word[idx]);
      end
      held = rsp_rdata;
      for (int k = 0; k < bp; k++) begin
         req_valid = 1'b1;
         req_addr  = 32'h4;
         req_wen   = 1'b1;
         req_be    = 4'hF;
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rdata", rsp_rdata, held);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_req_ready", 32'(req_ready), 32'd1);
      if (w && !e) m_store(a, d, be);
   endtask

   // Store aborted by reset sampled off edges after accept (1..L)
   task automatic xact_reset(input logic [31:0] a, input logic [31:0] d, input int off);
      bit ok;
      @(negedge clk);
      rsp_ready = 1'b1;
      issue(a, 1'b1, d, 4'hF, ok);
      if (!ok) return;
      for (int k = 1; k < off; k++) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rstmid_valid", 32'(rsp_valid), 32'd0);
         chk("rstmid_rdata", rsp_rdata, 32'h0);
         chk("rstmid_err", 32'(rsp_err), 32'd0);
         chk("rstmid_req_ready", 32'(req_ready), 32'd0);
      end
      rst = 1'b0;
      for (int k = 0; k < L + 3; k++) begin
         @(negedge clk);
         chk("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
      end
      chk("rstmid_ready_after", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      logic        w;
      int          r;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      req_wen   = 1'b0;
      req_wdata = 32'h0;
      req_be    = 4'h0;
      rsp_ready = 1'b1;

      // Reset held for 3 cycles
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_valid", 32'(rsp_valid), 32'd0);
         chk("rst_rdata", rsp_rdata, 32'h0);
         chk("rst_err", 32'(rsp_err), 32'd0);
         chk("rst_req_ready", 32'(req_ready), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(req_ready), 32'd1);

      // Directed: store/load, byte enables, errors
      xact(32'h0,  1'b1, 32'h0BADF00D, 4'hF, 0, got);
      xact(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, got);
      xact(32'h10, 1'b0, 32'h0,        4'h0, 0, got);
      chk("load_deadbeef", got, 32'hDEADBEEF);
      xact(32'h10, 1'b1, 32'h11223344, 4'b0101, 0, got);
      xact(32'h10, 1'b0, 32'h0,        4'hF, 0, got);
      chk("byte_merge", got, 32'hDE22BE44);
      xact(32'h10, 1'b1, 32'h55667788, 4'h0, 0, got);
      xact(32'h12, 1'b0, 32'h0,        4'h0, 0, got);
      xact(32'h1000, 1'b1, 32'hFFFFFFFF, 4'hF, 0, got);
      xact(32'h0,  1'b0, 32'h0,        4'h0, 0, got);
      chk("load_0_unchanged", got, 32'h0BADF00D);

      // Backpressure on a load response
      xact(32'h10, 1'b0, 32'h0, 4'h0, 5, got);
      chk("bp_load_data", got, 32'hDE22BE44);

      // Reset mid-WAIT, then on the access edge
      xact(32'h20, 1'b1, 32'h01234567, 4'hF, 0, got);
      xact_reset(32'h20, 32'hCAFEF00D, 1);
      xact(32'h20, 1'b0, 32'h0, 4'h0, 0, got);
      chk("rstmid_preserved", got, 32'h01234567);
      xact_reset(32'h20, 32'hCAFEF00D, L);
      xact(32'h20, 1'b0, 32'h0, 4'h0, 0, got);
      chk("rst_on_access_edge", got, 32'h01234567);

      // Randomized traffic against the reference model
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      a = $urandom | 32'h0001_0000;
         else if (r == 1) a = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
         else if (r == 2) a = 32'hFFC;
         else             a = $urandom_range(0, 15) * 4;
         w = 1'($urandom_range(0, 1));
         xact(a, w, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), got);
      end
      xact_reset(32'h8, 32'hA5A5A5A5, $urandom_range(1, L));
      for (int i = 0; i < 16; i++) begin
         xact(32'(i * 4), 1'b0, 32'h0, 4'h0, 0, got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dmem_responder
`default_nettype wire
